// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for serial_adder
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             busy;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, carry, busy
   );
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, carry, busy
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, carry, busy
   );
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, carry, busy
   );
`endif
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder evaluation per cycle, LSB first
// Defining SERIAL_ADDER_SUB_EN adds a sub input that computes a + ~b + 1.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [CW-1:0]    count;
   logic             carry_reg;
   logic             fa_sum;
   logic             fa_carry;

   function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
      return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

   // The single adder cell: carry_reg closes the loop from one bit to the next.
   always_comb begin
      {fa_carry, fa_sum} = full_adder(a_sr[0], b_sr[0], carry_reg);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         a_sr          <= '0;
         b_sr          <= '0;
         sum_sr        <= '0;
         count         <= '0;
         carry_reg     <= 1'b0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.sum       <= '0;
         bus.carry     <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sr         <= bus.a;
`ifdef SERIAL_ADDER_SUB_EN
                  b_sr         <= bus.sub ? ~bus.b : bus.b;
                  carry_reg    <= bus.sub ? 1'b1 : bus.cin;
`else
                  b_sr         <= bus.b;
                  carry_reg    <= bus.cin;
`endif
                  count        <= '0;
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b1;
                  state        <= RUN;
               end
            end
            RUN: begin
               a_sr      <= a_sr >> 1;
               b_sr      <= b_sr >> 1;
               sum_sr    <= {fa_sum, sum_sr[WIDTH-1:1]};
               carry_reg <= fa_carry;
               count     <= count + CW'(1);
               // The last bit lands straight in the output register, saving a cycle.
               if (count == LAST) begin
                  bus.sum       <= {fa_sum, sum_sr[WIDTH-1:1]};
                  bus.carry     <= fa_carry;
                  bus.out_valid <= 1'b1;
                  state         <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  bus.busy      <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
